// File: rtl/rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Field widths here set the default widths of rs_unified.
package rs_pkg;

    localparam int RS_ROB_W  = 4;
    localparam int RS_DATA_W = 32;
    localparam int RS_ADDR_W = 32;
    localparam int RS_OP_W   = 6;

    localparam logic [RS_OP_W-1:0]  NOP    = 6'h3F;
    localparam logic [RS_ROB_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic                 busy;
        logic [RS_OP_W-1:0]   opcode;
        logic [RS_DATA_W-1:0] a;
        logic [RS_ROB_W-1:0]  qj;
        logic [RS_DATA_W-1:0] vj;
        logic [RS_ROB_W-1:0]  qk;
        logic [RS_DATA_W-1:0] vk;
        logic [RS_ROB_W-1:0]  dest;
        logic [RS_ADDR_W-1:0] pc;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready slot that no other ready slot is older than.
module rs_age_select #(
    parameter int ENTRIES = 16
) (
    input  logic [ENTRIES-1:0]              ready,
    input  logic [ENTRIES-1:0][ENTRIES-1:0] age,
    output logic [ENTRIES-1:0]              grant,
    output logic                            found
);

    // age[j][i] = 1 means slot j was allocated before slot i
    always_comb begin
        grant = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && ready[j] && age[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    assign found = |ready;

endmodule

// File: rtl/rs_unified.sv
// ALU reservation station: age-ordered issue, multi-channel CDB wakeup,
// dispatch-cycle operand bypass and a valid/ready issue register.
module rs_unified
    import rs_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ROB_W   = RS_ROB_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int ADDR_W  = RS_ADDR_W,
    parameter int OP_W    = RS_OP_W,
    parameter int CDB_N   = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        disp_en_in,
    input  logic [OP_W-1:0]             disp_opcode_in,
    input  logic [DATA_W-1:0]           disp_a_in,
    input  logic [ROB_W-1:0]            disp_qj_in,
    input  logic [ROB_W-1:0]            disp_qk_in,
    input  logic [DATA_W-1:0]           disp_vj_in,
    input  logic [DATA_W-1:0]           disp_vk_in,
    input  logic [ROB_W-1:0]            disp_dest_in,
    input  logic [ADDR_W-1:0]           disp_pc_in,
    output logic                        rs_rdy_out,
    output logic [$clog2(ENTRIES):0]    occupancy_out,
    input  logic [CDB_N*ROB_W-1:0]      cdb_tag_in,
    input  logic [CDB_N*DATA_W-1:0]     cdb_data_in,
    output logic                        issue_valid_out,
    input  logic                        issue_ready_in,
    output logic [OP_W-1:0]             issue_opcode_out,
    output logic [DATA_W-1:0]           issue_a_out,
    output logic [DATA_W-1:0]           issue_vj_out,
    output logic [DATA_W-1:0]           issue_vk_out,
    output logic [ROB_W-1:0]            issue_dest_out,
    output logic [ADDR_W-1:0]           issue_pc_out
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t                       slots [ENTRIES];
    rs_entry_t                       disp_entry;
    logic [ENTRIES-1:0][ENTRIES-1:0] age;
    logic [ENTRIES-1:0]              busy_vec;
    logic [ENTRIES-1:0]              ready_vec;
    logic [ENTRIES-1:0]              grant;
    logic                            found;
    logic [IDX_W-1:0]                sel_idx;
    logic [IDX_W-1:0]                alloc_idx;
    logic                            disp_fire;
    logic                            issue_load;
    logic [DATA_W:0]                 byp_j;
    logic [DATA_W:0]                 byp_k;
    logic [DATA_W:0]                 wake_j [ENTRIES];
    logic [DATA_W:0]                 wake_k [ENTRIES];

    // Returns {hit, data}; scanning high to low lets the lowest channel win
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]        tag,
        input logic [CDB_N*ROB_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] data
    );
        logic [DATA_W:0] result;
        result = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (tag != NO_TAG && tags[c*ROB_W +: ROB_W] == tag) begin
                result = {1'b1, data[c*DATA_W +: DATA_W]};
            end
        end
        return result;
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            busy_vec[i]  = slots[i].busy;
            ready_vec[i] = slots[i].busy && slots[i].qj == NO_TAG && slots[i].qk == NO_TAG;
            wake_j[i]    = cdb_lookup(slots[i].qj, cdb_tag_in, cdb_data_in);
            wake_k[i]    = cdb_lookup(slots[i].qk, cdb_tag_in, cdb_data_in);
        end
    end

    always_comb begin
        occupancy_out = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occupancy_out = occupancy_out + CNT_W'(busy_vec[i]);
        end
    end

    assign rs_rdy_out = ~&busy_vec;

    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    rs_age_select #(
        .ENTRIES(ENTRIES)
    ) u_age_select (
        .ready(ready_vec),
        .age  (age),
        .grant(grant),
        .found(found)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Operands broadcast in the dispatch cycle are captured straight into the new entry
    always_comb begin
        byp_j             = cdb_lookup(disp_qj_in, cdb_tag_in, cdb_data_in);
        byp_k             = cdb_lookup(disp_qk_in, cdb_tag_in, cdb_data_in);
        disp_entry.busy   = 1'b1;
        disp_entry.opcode = disp_opcode_in;
        disp_entry.a      = disp_a_in;
        disp_entry.qj     = byp_j[DATA_W] ? NO_TAG : disp_qj_in;
        disp_entry.vj     = byp_j[DATA_W] ? byp_j[DATA_W-1:0] : disp_vj_in;
        disp_entry.qk     = byp_k[DATA_W] ? NO_TAG : disp_qk_in;
        disp_entry.vk     = byp_k[DATA_W] ? byp_k[DATA_W-1:0] : disp_vk_in;
        disp_entry.dest   = disp_dest_in;
        disp_entry.pc     = disp_pc_in;
    end

    assign disp_fire  = disp_en_in && rs_rdy_out;
    assign issue_load = found && (!issue_valid_out || issue_ready_in);

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush_in)) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= '0;
            end
            age              <= '0;
            issue_valid_out  <= 1'b0;
            issue_opcode_out <= NOP;
            issue_a_out      <= '0;
            issue_vj_out     <= '0;
            issue_vk_out     <= '0;
            issue_dest_out   <= '0;
            issue_pc_out     <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (slots[i].busy && wake_j[i][DATA_W]) begin
                    slots[i].vj <= wake_j[i][DATA_W-1:0];
                    slots[i].qj <= NO_TAG;
                end
                if (slots[i].busy && wake_k[i][DATA_W]) begin
                    slots[i].vk <= wake_k[i][DATA_W-1:0];
                    slots[i].qk <= NO_TAG;
                end
            end

            if (issue_load) begin
                issue_valid_out        <= 1'b1;
                issue_opcode_out       <= slots[sel_idx].opcode;
                issue_a_out            <= slots[sel_idx].a;
                issue_vj_out           <= slots[sel_idx].vj;
                issue_vk_out           <= slots[sel_idx].vk;
                issue_dest_out         <= slots[sel_idx].dest;
                issue_pc_out           <= slots[sel_idx].pc;
                slots[sel_idx].busy    <= 1'b0;
            end else if (issue_ready_in) begin
                issue_valid_out <= 1'b0;
            end

            // The new slot becomes younger than every slot already holding an instruction
            if (disp_fire) begin
                slots[alloc_idx] <= disp_entry;
                age[alloc_idx]   <= '0;
                for (int j = 0; j < ENTRIES; j++) begin
                    if (busy_vec[j]) begin
                        age[j][alloc_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // A full station drops dispatches; recorded so simulation shows when upstream ignored rs_rdy_out
    dispatch_dropped_when_full: cover property (
        @(posedge clk_in) disable iff (rst_in)
        rdy_in && !flush_in && disp_en_in && !rs_rdy_out
    );

endmodule

// File: doc/rs_unified.md
Name: rs_unified

Overview:
- Parametrised reservation station for the ALU path: holds up to ENTRIES renamed instructions and captures operands from CDB_N common-data-bus channels.
- Issues the oldest entry whose operands are all ready to one ALU port over a valid/ready handshake.
- Sits between the dispatcher and the ALU. Replaces the fixed-size, single-order station with age-ordered selection, multi-channel wakeup, dispatch-cycle bypass and issue back-pressure.

Parameters:
- ENTRIES, 16, number of station slots; power of two, at least 2.
- ROB_W, 4, ROB tag width. Tag 0 means "no dependency" / "no broadcast".
- DATA_W, 32, operand and immediate width.
- ADDR_W, 32, PC width.
- OP_W, 6, internal opcode width.
- CDB_N, 2, number of CDB broadcast channels.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when low, all state holds
- flush_in  in  1  misprediction flush from the ROB
- disp_en_in  in  1  dispatch strobe
- disp_opcode_in  in  OP_W  opcode
- disp_a_in  in  DATA_W  immediate
- disp_qj_in, disp_qk_in  in  ROB_W  source tags
- disp_vj_in, disp_vk_in  in  DATA_W  source values
- disp_dest_in  in  ROB_W  destination ROB tag
- disp_pc_in  in  ADDR_W  instruction PC
- rs_rdy_out  out  1  at least one free slot
- occupancy_out  out  $clog2(ENTRIES)+1  number of busy slots
- cdb_tag_in  in  CDB_N*ROB_W  broadcast tags; channel c is at bits [c*ROB_W +: ROB_W]
- cdb_data_in  in  CDB_N*DATA_W  broadcast results
- issue_valid_out  out  1  issue register holds an instruction
- issue_ready_in  in  1  ALU accepts the instruction
- issue_opcode_out, issue_a_out, issue_vj_out, issue_vk_out, issue_dest_out, issue_pc_out  out  widths as the matching dispatch fields

Behaviour:
- Reset (synchronous; rst_in wins over everything, including rdy_in low):
  - all busy bits 0; age matrix cleared; issue_valid_out=0.
  - all issue_*_out fields 0, except issue_opcode_out = NOP.
  - rs_rdy_out=1, occupancy_out=0.
- rdy_in=0: no state changes; CDB broadcasts in that cycle are ignored.
- flush_in=1 (with rdy_in=1): same effect as reset at the next edge. Overrides dispatch, wakeup and issue in that cycle.
- Allocation:
  - On disp_en_in && rs_rdy_out, write the lowest-index free slot.
  - A dispatch while full is dropped silently; flag it with a simulation-only assertion.
- Dispatch bypass: if disp_qj_in != 0 and it equals a CDB tag in the same cycle, store that channel's data in vj and clear qj. Same rule for qk.
- Wakeup: for each busy slot and each channel c with tag != 0, a match on qj/qk loads the data and clears the tag at the edge. On duplicate tags across channels, the lowest channel wins.
- Ready condition: slot busy, qj==0 and qk==0, evaluated on registered state. A slot woken at edge E is selectable in the cycle after E.
- Age order:
  - ENTRIES×ENTRIES matrix; age[i][j]=1 means slot i is older than slot j.
  - On allocating slot k: row k is cleared and column k is set for all busy slots.
  - Selection picks the ready slot that no other ready slot is older than.
- Issue register:
  - Loads when (!issue_valid_out || issue_ready_in) and a ready slot exists. The selected slot's busy bit clears at the same edge.
  - If nothing is ready and the current instruction is accepted, issue_valid_out drops to 0.
  - While issue_valid_out && !issue_ready_in, outputs hold stable.
- Minimum latency: dispatch with both operands ready at edge 0 gives issue_valid_out=1 after edge 1.
- Simultaneous events:
  - Issue and dispatch may both happen in one cycle. The freed slot is not reusable until the next cycle because rs_rdy_out uses registered busy bits.
  - occupancy_out = popcount(busy), registered.
- Opcodes are not interpreted. Immediate-only ops are dispatched with qj=qk=0.

Decomposition:
- rs_pkg holds:
  - the NOP opcode constant;
  - the NO_TAG = 0 constant;
  - the entry struct typedef (busy, opcode, a, qj, vj, qk, vk, dest, pc).
- One sub-module, rs_age_select: inputs ENTRIES ready bits and the age matrix; outputs a one-hot grant and a found flag. Purely combinational, parametrised on ENTRIES.

Test Plan:
- Reset, then dispatch ADD with qj=qk=0, vj=5, vk=7, dest=3 → issue_valid_out=1 after edge 1, issue_vj=5, issue_vk=7, issue_dest=3; occupancy returns to 0.
- Dispatch A (qj=2) then B (ready) → B issues first. Broadcast tag 2, data 0x10 on channel 1 → A issues two edges later with vj=0x10.
- Dispatch with qk=4 while channel 0 broadcasts tag 4, data 0xAB → entry is ready immediately; issues at edge 1 with vk=0xAB.
- Three ready entries with issue_ready_in=0 → outputs hold the oldest entry. Raise issue_ready_in → the remaining two issue in age order on consecutive cycles.
- Fill all 16 slots → rs_rdy_out=0 and occupancy_out=16; a 17th dispatch is dropped. After one issue, rs_rdy_out returns to 1 the following cycle.
- Flush with 5 busy slots and issue_valid_out=1 → next edge: occupancy_out=0, issue_valid_out=0. A later broadcast of an old tag has no effect.
